// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch (p0) and data (p1) share one
// single-cycle-latency memory with round-robin arbitration and a bounded p1 lock.
module mem_arbiter #(
    parameter int unsigned DW       = 16,
    parameter int unsigned AW       = 16,
    parameter int unsigned LOCK_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic [AW-1:0] p0_addr,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    input  logic          p1_lock,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned CW = $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {IDLE, G0, G1, LK} state_t;

    state_t        state_q, state_d;
    logic          rr_q, rr_d;      // last granted port: 0 = p0, 1 = p1
    logic [CW-1:0] cnt_q, cnt_d;
    logic          gnt0, gnt1;
    logic          lock_hold;

    // State, round-robin pointer and lock counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Grant decision and next-state; grants are forced low while in reset
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        state_d   = IDLE;
        rr_d      = rr_q;
        cnt_d     = '0;
        lock_hold = (state_q == LK) && p1_req && (cnt_q < CW'(LOCK_MAX));

        if (rst) begin
            if (lock_hold) begin
                gnt1 = 1'b1;
            end else if (p0_req && p1_req) begin
                gnt0 = rr_q;
                gnt1 = !rr_q;
            end else begin
                gnt0 = p0_req;
                gnt1 = p1_req && !p0_req;
            end
        end

        if (gnt0) begin
            state_d = G0;
            rr_d    = 1'b0;
        end else if (gnt1) begin
            rr_d = 1'b1;
            if (p1_lock) begin
                state_d = LK;
                // Saturate so p0 keeps priority until it is actually served
                cnt_d   = (cnt_q < CW'(LOCK_MAX)) ? cnt_q + CW'(1) : cnt_q;
            end else begin
                state_d = G1;
            end
        end
    end

    // Read-return tracking: one cycle after a granted read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
        end else begin
            p0_rvalid <= gnt0;
            p1_rvalid <= gnt1 && !p1_we;
        end
    end

    assign p0_gnt    = gnt0;
    assign p1_gnt    = gnt1;
    assign mem_en    = gnt0 || gnt1;
    assign mem_we    = gnt1 && p1_we;
    assign mem_addr  = gnt0 ? p0_addr : (gnt1 ? p1_addr : '0);
    assign mem_wdata = gnt1 ? p1_wdata : '0;
    assign p0_rdata  = p0_rvalid ? mem_rdata : '0;
    assign p1_rdata  = p1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected grants and read
// returns; a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p1_req, p1_we, p1_lock;
    logic [15:0] p0_addr, p1_addr, p1_wdata, mem_rdata;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic        mem_en, mem_we;
    logic [15:0] p0_rdata, p1_rdata, mem_addr, mem_wdata;

    typedef struct packed {
        logic        g0;
        logic        g1;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } gexp_t;

    typedef struct packed {
        logic        port;
        logic [15:0] data;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    mem_arbiter #(.DW(16), .AW(16), .LOCK_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_gnt(p0_gnt),
        .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_lock(p1_lock), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic gexp_t mk_g(logic g0, logic g1, logic we, logic [15:0] a, logic [15:0] d);
        gexp_t g;
        g.g0 = g0; g.g1 = g1; g.we = we; g.addr = a; g.wdata = d;
        return g;
    endfunction

    function automatic rexp_t mk_r(logic port, logic [15:0] d);
        rexp_t r;
        r.port = port; r.data = d;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: grants/memory side and read returns
    always @(negedge clk) begin
        gexp_t g;
        rexp_t r;
        if (p0_gnt || p1_gnt || mem_en) begin
            if (gq.size() == 0) begin
                chk("unexpected_grant", {p0_gnt, p1_gnt}, 2'b00);
            end else begin
                g = gq.pop_front();
                chk("grant", {p0_gnt, p1_gnt, mem_we, mem_addr, mem_wdata}, g);
                chk("mem_en", mem_en, 1'b1);
            end
        end else begin
            chk("idle_mem", {mem_we, mem_addr, mem_wdata}, 33'd0);
        end
        if (p0_rvalid || p1_rvalid) begin
            if (rq.size() == 0 || (p0_rvalid && p1_rvalid)) begin
                chk("unexpected_rvalid", {p0_rvalid, p1_rvalid}, 2'b00);
            end else begin
                r = rq.pop_front();
                chk("rvalid_port", {p0_rvalid, p1_rvalid}, {!r.port, r.port});
                chk("rdata", r.port ? p1_rdata : p0_rdata, r.data);
                chk("rdata_other_zero", r.port ? p0_rdata : p1_rdata, 16'd0);
            end
        end else begin
            chk("rdata_idle", {p0_rdata, p1_rdata}, 32'd0);
        end
    end

    task automatic chk_reset_outputs();
        @(negedge clk);
        chk("rst_gnt", {p0_gnt, p1_gnt}, 2'b00);
        chk("rst_mem", {mem_en, mem_we}, 2'b00);
        chk("rst_rvalid", {p0_rvalid, p1_rvalid}, 2'b00);
    endtask

    initial begin
        logic port;
        rst = 1'b0;
        p0_req = 1'b1; p1_req = 1'b1; p1_we = 1'b0; p1_lock = 1'b0;
        p0_addr = 16'h0; p1_addr = 16'h0; p1_wdata = 16'h0; mem_rdata = 16'h0;

        // Requests held during reset must not be granted
        tick();
        chk_reset_outputs();
        tick();
        rst = 1'b1;

        // Both read every cycle: p0 wins first tie, then alternate
        for (int i = 0; i < 4; i++) begin
            p0_addr   = 16'h0020 + 16'(i);
            p1_addr   = 16'h0030 + 16'(i);
            mem_rdata = (i == 0) ? 16'h0 : 16'h5000 + 16'(i - 1);
            if (i > 0) rq.push_back(mk_r(((i - 1) % 2) == 1, 16'h5000 + 16'(i - 1)));
            if (i % 2 == 0) gq.push_back(mk_g(1'b1, 1'b0, 1'b0, 16'h0020 + 16'(i), 16'h0));
            else            gq.push_back(mk_g(1'b0, 1'b1, 1'b0, 16'h0030 + 16'(i), 16'h0));
            tick();
        end

        // Lone p0 read at 0x0010
        p1_req = 1'b0; p0_addr = 16'h0010; mem_rdata = 16'h5003;
        rq.push_back(mk_r(1'b1, 16'h5003));
        gq.push_back(mk_g(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0));
        tick();

        // p1 write issued in the same cycle p0's read data returns
        p0_req = 1'b0; p1_req = 1'b1; p1_we = 1'b1; p1_addr = 16'h0100; p1_wdata = 16'h1234;
        mem_rdata = 16'hABCD;
        rq.push_back(mk_r(1'b0, 16'hABCD));
        gq.push_back(mk_g(1'b0, 1'b1, 1'b1, 16'h0100, 16'h1234));
        tick();

        // p0 read so that p1 owns the next tie
        p1_req = 1'b0; p1_we = 1'b0; p1_wdata = 16'h0;
        p0_req = 1'b1; p0_addr = 16'h0040; mem_rdata = 16'h0;
        gq.push_back(mk_g(1'b1, 1'b0, 1'b0, 16'h0040, 16'h0));
        tick();

        // Locked p1 vs p0 for 7 cycles: p1 x4, p0, p1, p1
        port = 1'b0;
        for (int i = 0; i < 7; i++) begin
            p0_req = 1'b1; p1_req = 1'b1; p1_lock = 1'b1;
            p0_addr = 16'h0070 + 16'(i);
            p1_addr = 16'h0060 + 16'(i);
            if (i == 0) begin
                mem_rdata = 16'h4444;
                rq.push_back(mk_r(1'b0, 16'h4444));
            end else begin
                mem_rdata = 16'h6000 + 16'(i - 1);
                rq.push_back(mk_r(port, 16'h6000 + 16'(i - 1)));
            end
            port = (i != 4);
            if (port) gq.push_back(mk_g(1'b0, 1'b1, 1'b0, 16'h0060 + 16'(i), 16'h0));
            else      gq.push_back(mk_g(1'b1, 1'b0, 1'b0, 16'h0070 + 16'(i), 16'h0));
            tick();
        end
        p0_req = 1'b0; p1_req = 1'b0; p1_lock = 1'b0; mem_rdata = 16'h6006;
        rq.push_back(mk_r(1'b1, 16'h6006));
        tick();

        // p1 read, then reset in the following cycle discards its return
        p1_req = 1'b1; p1_addr = 16'h0200; mem_rdata = 16'h0;
        gq.push_back(mk_g(1'b0, 1'b1, 1'b0, 16'h0200, 16'h0));
        tick();
        rst = 1'b0;
        p0_req = 1'b1; p1_req = 1'b1; p0_addr = 16'h0300; p1_addr = 16'h0301;
        mem_rdata = 16'h9999;
        chk_reset_outputs();
        tick();
        chk_reset_outputs();
        tick();
        rst = 1'b1;
        gq.push_back(mk_g(1'b1, 1'b0, 1'b0, 16'h0300, 16'h0));
        tick();
        p0_req = 1'b0; p1_req = 1'b0; mem_rdata = 16'h7777;
        rq.push_back(mk_r(1'b0, 16'h7777));
        tick();
        mem_rdata = 16'h0;

        for (int k = 0; k < 20 && (gq.size() != 0 || rq.size() != 0); k++) tick();
        chk("grants_outstanding", 64'(gq.size()), 64'd0);
        chk("reads_outstanding", 64'(rq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
